gumnut_exec_sequencer: RTL and testbench
========================================

# gumnut_exec_sequencer

Issue and writeback sequencer for the Gumnut ALU datapath. Accepts one 18-bit instruction at a time over a valid/ready handshake and decodes it. Holds the 8×8 general-purpose register file and drives the ALU's IR and operand inputs. Captures the ALU result into the destination register and updates the Z/C condition codes. Only ALU-register, ALU-immediate and shift classes are executed; every other class is flagged illegal.

## Interface
- No parameters. Widths are fixed by the Gumnut ISA: 18-bit IR, 8-bit data, 8 registers.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- instr_valid  in  1  instr holds a new instruction
- instr  in  18  instruction word
- instr_ready  out  1  sequencer can accept; high only in IDLE
- alu_ir  out  18  registered IR presented to the ALU
- alu_rs  out  8  registered value of R[IR[10:8]]
- alu_r2  out  8  registered value of R[IR[7:5]]
- alu_result  in  8  ALU arithmetic/logic result
- alu_shift_result  in  8  ALU shift result
- alu_c  in  1  ALU carry out
- cc_z  out  1  zero flag
- cc_c  out  1  carry flag
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse, coincident with done, for a non-executable class
- dbg_addr  in  3  register-file debug read address
- dbg_data  out  8  combinational R[dbg_addr]; reads 0 when dbg_addr=0

## Operation
- Decode classes:
  - ALU-immediate: IR[17]=0
  - shift: IR[17:15]=110
  - ALU-register: IR[17:14]=1110
  - anything else is illegal.
- Decode fields: rd=IR[13:11], rs=IR[10:8], r2=IR[7:5].
- R0 reads as 0 at all times; writes to R0 are discarded.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid, latch instr into alu_ir and go to READ. instr_valid outside IDLE is ignored and not queued.
  - READ: register alu_rs←R[rs] and alu_r2←R[r2]. Illegal class goes to WB with no capture.
  - EXEC: ALU inputs are stable. Capture a result: alu_shift_result for the shift class, otherwise alu_result. Capture alu_c.
  - WB: legal class writes the captured result to R[rd], sets cc_z to (result==0) and cc_c to the captured carry. Pulse done; illegal class also pulses illegal and changes neither registers nor flags. Return to IDLE.
- Flags update on every legal instruction, including when rd=0.
- The register write and flag update occur together at the WB→IDLE edge.

## Timing
- Reset values:
  - state=IDLE, instr_ready=1
  - alu_ir=0, alu_rs=0, alu_r2=0
  - R1..R7=0, cc_z=0, cc_c=0
  - done=0, illegal=0
- Handshake edge is edge 0 (instr_valid & instr_ready). READ during cycle 1, EXEC cycle 2, WB cycle 3 with done high.
- The register write is visible on dbg_data after edge 4.
- instr_ready is high again in cycle 4. Maximum throughput is one instruction per 4 cycles.
- Read-after-write: the next instruction's READ occurs after the previous write, so no forwarding is required.
- A reset asserted in any state aborts immediately: no writeback, no done, all state returns to reset values.
- dbg_data is purely combinational and is unaffected by FSM state.

## Test plan
- Reset, then ADDI r1,r0,0x05 (instr=0x00805), ALU modeled → done in cycle 3 after accept, R1=0x05, cc_z=0.
- Follow with SUBI r2,r1,0x05 (0x09105) → R2=0x00, cc_z=1, cc_c=alu_c sampled in EXEC.
- SHL r3,r1,count 2 (0x31940), shift model returns 0x14 on alu_shift_result → R3=0x14, and alu_result is ignored.
- ADDI r0,r0,0x33 (0x00033) → done pulse, R0 still reads 0, cc_z=0; memory-class instr 0x20000 → done and illegal pulse, registers and flags unchanged.
- Hold instr_valid high continuously with different instructions → exactly one accepted per 4 cycles; instr_ready low in READ, EXEC and WB.
- Assert rst during EXEC of ADDI r4,r0,0x7F → R4 stays 0, no done, instr_ready=1 immediately.

Source files
------------

// File: rtl/gumnut_exec_sequencer.sv
// Purpose: issue/writeback sequencer for the Gumnut ALU; owns the 8x8 register file and Z/C flags.
// Latency: accept edge -> READ -> EXEC -> WB (done in cycle 3, cycle 2 for illegal); write lands on the WB exit edge.
// Backpressure: instr_ready is high only in IDLE; instr_valid seen while busy is ignored, never queued.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   instr_valid/instr/instr_ready   instruction handshake (18-bit Gumnut IR)
//   alu_ir, alu_rs, alu_r2   registered IR and source operands driven to the ALU
//   alu_result, alu_shift_result, alu_c   ALU outputs, captured in EXEC
//   cc_z, cc_c               condition codes
//   done, illegal            retire pulses (illegal coincides with done)
//   dbg_addr, dbg_data       combinational register-file debug read port

module gumnut_exec_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [17:0] instr,
    output logic        instr_ready,
    output logic [17:0] alu_ir,
    output logic [7:0]  alu_rs,
    output logic [7:0]  alu_r2,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  alu_shift_result,
    input  logic        alu_c,
    output logic        cc_z,
    output logic        cc_c,
    output logic        done,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    logic [1:0] state;
    logic [7:0] regs [0:7];
    logic [7:0] res_q;
    logic       carry_q;

    // Decode always works from the latched IR, which is frozen from READ through WB.
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] r2;
    logic       is_imm;
    logic       is_shift;
    logic       is_reg;
    logic       is_legal;

    assign rd       = alu_ir[13:11];
    assign rs       = alu_ir[10:8];
    assign r2       = alu_ir[7:5];
    assign is_imm   = ~alu_ir[17];
    assign is_shift = (alu_ir[17:15] == 3'b110);
    assign is_reg   = (alu_ir[17:14] == 4'b1110);
    assign is_legal = is_imm | is_shift | is_reg;

    // R0 is hard-wired to zero on every read path.
    logic [7:0] rs_val;
    logic [7:0] r2_val;

    assign rs_val   = (rs == 3'd0)       ? 8'h00 : regs[rs];
    assign r2_val   = (r2 == 3'd0)       ? 8'h00 : regs[r2];
    assign dbg_data = (dbg_addr == 3'd0) ? 8'h00 : regs[dbg_addr];

    assign instr_ready = (state == ST_IDLE);
    assign done        = (state == ST_WB);
    assign illegal     = (state == ST_WB) & ~is_legal;

    // Sequencer state, ALU operand registers and the EXEC capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            alu_ir  <= 18'h0;
            alu_rs  <= 8'h00;
            alu_r2  <= 8'h00;
            res_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        alu_ir <= instr;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_rs <= rs_val;
                    alu_r2 <= r2_val;
                    // Non-executable classes skip EXEC entirely; nothing is captured.
                    state  <= is_legal ? ST_EXEC : ST_WB;
                end
                ST_EXEC: begin
                    res_q   <= is_shift ? alu_shift_result : alu_result;
                    carry_q <= alu_c;
                    state   <= ST_WB;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file and flags: both commit on the WB -> IDLE edge, legal classes only.
    // Flags update even when rd is R0; only the register write is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
            cc_z <= 1'b0;
            cc_c <= 1'b0;
        end else if (state == ST_WB && is_legal) begin
            if (rd != 3'd0) begin
                regs[rd] <= res_q;
            end
            cc_z <= (res_q == 8'h00);
            cc_c <= carry_q;
        end
    end

endmodule

// File: tb/tb_gumnut_exec_sequencer.sv
module tb_gumnut_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [17:0] instr = 18'h0;
    logic        instr_ready;
    logic [17:0] alu_ir;
    logic [7:0]  alu_rs;
    logic [7:0]  alu_r2;
    logic [7:0]  alu_result;
    logic [7:0]  alu_shift_result;
    logic        alu_c;
    logic        cc_z;
    logic        cc_c;
    logic        done;
    logic        illegal;
    logic [2:0]  dbg_addr = 3'd0;
    logic [7:0]  dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gumnut_exec_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_ready      (instr_ready),
        .alu_ir           (alu_ir),
        .alu_rs           (alu_rs),
        .alu_r2           (alu_r2),
        .alu_result       (alu_result),
        .alu_shift_result (alu_shift_result),
        .alu_c            (alu_c),
        .cc_z             (cc_z),
        .cc_c             (cc_c),
        .done             (done),
        .illegal          (illegal),
        .dbg_addr         (dbg_addr),
        .dbg_data         (dbg_data)
    );

    // Small ALU model: add/sub immediate, register add, shift-left.
    // alu_result is parked at 0xEE for shifts so a wrong capture mux shows up.
    logic [15:0] shl_tmp;
    always_comb begin
        alu_result       = 8'hEE;
        alu_shift_result = 8'hEE;
        alu_c            = 1'b0;
        shl_tmp          = 16'h0;
        if (!alu_ir[17]) begin
            case (alu_ir[16:14])
                3'b000:  {alu_c, alu_result} = {1'b0, alu_rs} + {1'b0, alu_ir[7:0]};
                3'b010:  {alu_c, alu_result} = {1'b0, alu_rs} - {1'b0, alu_ir[7:0]};
                default: alu_result = alu_rs ^ alu_ir[7:0];
            endcase
        end else if (alu_ir[17:15] == 3'b110) begin
            shl_tmp          = {8'h00, alu_rs} << alu_ir[7:5];
            alu_shift_result = shl_tmp[7:0];
            alu_c            = (alu_ir[7:5] == 3'd0) ? 1'b0 : shl_tmp[8];
        end else if (alu_ir[17:14] == 4'b1110) begin
            {alu_c, alu_result} = {1'b0, alu_rs} + {1'b0, alu_r2};
        end
    end

    // Hand one instruction over, then follow it to retirement.
    // dcyc = cycle after accept in which done was seen (0 = never within budget).
    // busy_rdy = instr_ready seen high in any cycle before retirement.
    // Returns at the negedge of the cycle after retirement.
    task automatic issue(input logic [17:0] w, output int dcyc, output logic ill,
                         output logic [7:0] rs_s, output logic [7:0] r2_s,
                         output logic busy_rdy);
        dcyc = 0; ill = 1'b0; rs_s = 8'h00; r2_s = 8'h00; busy_rdy = 1'b0;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 18'h0;
        for (int c = 1; c <= 8; c++) begin
            if (done) begin
                dcyc = c; ill = illegal; rs_s = alu_rs; r2_s = alu_r2;
                break;
            end
            busy_rdy = busy_rdy | instr_ready;
            @(negedge clk);
        end
        if (dcyc != 0) @(negedge clk);
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        n_tests++; if (alu_ir !== 18'h0) begin n_fail++; $display("FAIL reset_alu_ir got=%h exp=0", alu_ir); end
        n_tests++; if (alu_rs !== 8'h00 || alu_r2 !== 8'h00) begin n_fail++; $display("FAIL reset_operands got=%h/%h exp=00/00", alu_rs, alu_r2); end
        n_tests++; if (cc_z !== 1'b0 || cc_c !== 1'b0) begin n_fail++; $display("FAIL reset_flags got z=%b c=%b exp 0/0", cc_z, cc_c); end
        n_tests++; if (done !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got done=%b ill=%b exp 0/0", done, illegal); end
        for (int i = 0; i < 8; i++) begin
            rd_reg(i[2:0], v);
            n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg R%0d got=%h exp=00", i, v); end
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_imm;
        int d; logic il, br; logic [7:0] rs_s, r2_s, v;
        // ADDI r1,r0,0x05
        issue(18'h00805, d, il, rs_s, r2_s, br);
        n_tests++; if (d !== 3) begin n_fail++; $display("FAIL addi_done_cycle got=%0d exp=3", d); end
        n_tests++; if (il !== 1'b0) begin n_fail++; $display("FAIL addi_illegal got=%b exp=0", il); end
        n_tests++; if (br !== 1'b0) begin n_fail++; $display("FAIL addi_ready_busy got=%b exp=0", br); end
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready_after got=%b exp=1", instr_ready); end
        rd_reg(3'd1, v);
        n_tests++; if (v !== 8'h05) begin n_fail++; $display("FAIL addi_r1 got=%h exp=05", v); end
        n_tests++; if (cc_z !== 1'b0 || cc_c !== 1'b0) begin n_fail++; $display("FAIL addi_flags got z=%b c=%b exp 0/0", cc_z, cc_c); end
        // SUBI r2,r1,0x05
        issue(18'h09105, d, il, rs_s, r2_s, br);
        n_tests++; if (d !== 3) begin n_fail++; $display("FAIL subi_done_cycle got=%0d exp=3", d); end
        n_tests++; if (rs_s !== 8'h05) begin n_fail++; $display("FAIL subi_alu_rs got=%h exp=05", rs_s); end
        rd_reg(3'd2, v);
        n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL subi_r2 got=%h exp=00", v); end
        n_tests++; if (cc_z !== 1'b1 || cc_c !== 1'b0) begin n_fail++; $display("FAIL subi_flags got z=%b c=%b exp 1/0", cc_z, cc_c); end
    endtask

    task automatic test_illegal_mem;
        int d; logic il, br; logic [7:0] rs_s, r2_s, v;
        issue(18'h20000, d, il, rs_s, r2_s, br);
        n_tests++; if (d !== 2) begin n_fail++; $display("FAIL ill_done_cycle got=%0d exp=2", d); end
        n_tests++; if (il !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got=%b exp=1", il); end
        n_tests++; if (cc_z !== 1'b1 || cc_c !== 1'b0) begin n_fail++; $display("FAIL ill_flags_kept got z=%b c=%b exp 1/0", cc_z, cc_c); end
        rd_reg(3'd1, v);
        n_tests++; if (v !== 8'h05) begin n_fail++; $display("FAIL ill_r1_kept got=%h exp=05", v); end
        rd_reg(3'd0, v);
        n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL ill_r0 got=%h exp=00", v); end
    endtask

    task automatic test_shift;
        int d; logic il, br; logic [7:0] rs_s, r2_s, v;
        // SHL r3,r1,2
        issue(18'h31940, d, il, rs_s, r2_s, br);
        n_tests++; if (d !== 3 || il !== 1'b0) begin n_fail++; $display("FAIL shl_retire got cyc=%0d ill=%b exp 3/0", d, il); end
        rd_reg(3'd3, v);
        n_tests++; if (v !== 8'h14) begin n_fail++; $display("FAIL shl_r3 got=%h exp=14", v); end
        n_tests++; if (cc_z !== 1'b0 || cc_c !== 1'b0) begin n_fail++; $display("FAIL shl_flags got z=%b c=%b exp 0/0", cc_z, cc_c); end
    endtask

    task automatic test_carry_and_reg;
        int d; logic il, br; logic [7:0] rs_s, r2_s, v;
        // ADDI r5,r1,0xFF : 0x05+0xFF = 0x104
        issue(18'h029FF, d, il, rs_s, r2_s, br);
        rd_reg(3'd5, v);
        n_tests++; if (v !== 8'h04) begin n_fail++; $display("FAIL carry_r5 got=%h exp=04", v); end
        n_tests++; if (cc_z !== 1'b0 || cc_c !== 1'b1) begin n_fail++; $display("FAIL carry_flags got z=%b c=%b exp 0/1", cc_z, cc_c); end
        // class 1111 is not executable: carry must survive
        issue(18'h3C000, d, il, rs_s, r2_s, br);
        n_tests++; if (il !== 1'b1 || d !== 2) begin n_fail++; $display("FAIL ill2_pulse got ill=%b cyc=%0d exp 1/2", il, d); end
        n_tests++; if (cc_c !== 1'b1) begin n_fail++; $display("FAIL ill2_carry_kept got=%b exp=1", cc_c); end
        // ADD r7,r1,r5 (register class)
        issue(18'h3B9A0, d, il, rs_s, r2_s, br);
        n_tests++; if (r2_s !== 8'h04 || rs_s !== 8'h05) begin n_fail++; $display("FAIL addr_operands got rs=%h r2=%h exp 05/04", rs_s, r2_s); end
        rd_reg(3'd7, v);
        n_tests++; if (v !== 8'h09) begin n_fail++; $display("FAIL addr_r7 got=%h exp=09", v); end
        n_tests++; if (cc_c !== 1'b0 || il !== 1'b0) begin n_fail++; $display("FAIL addr_c_ill got c=%b ill=%b exp 0/0", cc_c, il); end
    endtask

    task automatic test_r0_write;
        int d; logic il, br; logic [7:0] rs_s, r2_s, v;
        // ADDI r0,r0,0x33
        issue(18'h00033, d, il, rs_s, r2_s, br);
        n_tests++; if (d !== 3) begin n_fail++; $display("FAIL r0a_done got=%0d exp=3", d); end
        rd_reg(3'd0, v);
        n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL r0a_r0 got=%h exp=00", v); end
        n_tests++; if (cc_z !== 1'b0 || cc_c !== 1'b0) begin n_fail++; $display("FAIL r0a_flags got z=%b c=%b exp 0/0", cc_z, cc_c); end
        // ADDI r0,r1,0xFB : 0x05+0xFB = 0x100, flags still update
        issue(18'h001FB, d, il, rs_s, r2_s, br);
        rd_reg(3'd0, v);
        n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL r0b_r0 got=%h exp=00", v); end
        n_tests++; if (cc_z !== 1'b1 || cc_c !== 1'b1) begin n_fail++; $display("FAIL r0b_flags got z=%b c=%b exp 1/1", cc_z, cc_c); end
    endtask

    task automatic test_back_to_back;
        int acc; logic [7:0] v;
        acc = 0;
        // ADDI r6,r6,k+1 offered every cycle; accepted at k = 0, 4, 8.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            instr = 18'h03600 | 18'(k + 1);
            instr_valid = 1'b1;
            #1;
            n_tests++; if (instr_ready !== ((k % 4) == 0)) begin n_fail++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, instr_ready, (k % 4) == 0); end
            n_tests++; if (done !== ((k % 4) == 3)) begin n_fail++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done, (k % 4) == 3); end
            if (instr_ready) acc++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 18'h0;
        n_tests++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=3", acc); end
        rd_reg(3'd6, v);
        n_tests++; if (v !== 8'h0F) begin n_fail++; $display("FAIL b2b_r6 got=%h exp=0F", v); end
    endtask

    task automatic test_reset_abort;
        int seen_done; logic [7:0] v;
        seen_done = 0;
        // ADDI r4,r0,0x7F, reset hits during EXEC
        @(negedge clk);
        instr = 18'h0207F;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);              // READ
        instr_valid = 1'b0;
        instr = 18'h0;
        @(negedge clk);              // EXEC
        rst = 1'b1;
        #1;
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", instr_ready); end
        n_tests++; if (done !== 1'b0 || alu_ir !== 18'h0) begin n_fail++; $display("FAIL abort_state got done=%b ir=%h exp 0/0", done, alu_ir); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        n_tests++; if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
        rd_reg(3'd4, v);
        n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL abort_r4 got=%h exp=00", v); end
        rd_reg(3'd1, v);
        n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL abort_r1_cleared got=%h exp=00", v); end
        n_tests++; if (cc_z !== 1'b0 || cc_c !== 1'b0) begin n_fail++; $display("FAIL abort_flags got z=%b c=%b exp 0/0", cc_z, cc_c); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_imm();
        test_illegal_mem();
        test_shift();
        test_carry_and_reg();
        test_r0_write();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
